// File: rtl/if_fetch_pkg.sv
// Shared widths, bus layouts and stall encoding for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned IF_TO_ID_WD  = 33;
    localparam int unsigned BR_WD        = 33;
    localparam int unsigned STALL_BUS_WD = 6;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic {
        NO_STOP = 1'b0,
        STOP    = 1'b1
    } stall_e;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// One-entry redirect buffer: remembers a redirect raised while IF is stalled
// and resolves the next fetch address (live redirect > pending > sequential).
module if_redirect_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if_i,
    input  logic        br_e_i,
    input  logic [31:0] br_addr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        pend_v_o
);

    logic        pend_v_q;
    logic [31:0] pend_addr_q;

    always_comb begin
        next_pc_o = seq_pc(pc_i);
        if (br_e_i) begin
            next_pc_o = br_addr_i;
        end else if (pend_v_q) begin
            next_pc_o = pend_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
        end else if (stall_if_i == NO_STOP) begin
            pend_v_q <= 1'b0;
        end else if (br_e_i) begin
            // Latest redirect overwrites any older pending one.
            pend_v_q    <= 1'b1;
            pend_addr_q <= br_addr_i;
        end
    end

    assign pend_v_o = pend_v_q;

endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: owns the PC and drives the instruction SRAM read port.
// Optional IF_ADEL_CHECK_EN adds if_adel and suppresses misaligned fetches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [BR_WD-1:0]        br_bus,
    output logic [IF_TO_ID_WD-1:0]  if_to_id_bus,
`ifdef IF_ADEL_CHECK_EN
    output logic                    if_adel,
`endif
    output logic                    inst_sram_en,
    output logic [3:0]              inst_sram_wen,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata
);

    br_bus_t     br;
    if_to_id_t   to_id;
    logic [31:0] pc_q;
    logic        ce_q;
    logic [31:0] next_pc;
    logic        fetch_ok;
    logic        pend_v_unused;
    logic        unused_stall;

    assign br           = br_bus_t'(br_bus);
    assign unused_stall = ^stall[STALL_BUS_WD-1:1];

    if_redirect_buf u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .stall_if_i (stall[0]),
        .br_e_i     (br.br_e),
        .br_addr_i  (br.br_addr),
        .pc_i       (pc_q),
        .next_pc_o  (next_pc),
        .pend_v_o   (pend_v_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC - 32'd4;
            ce_q <= 1'b0;
        end else if (stall[0] == NO_STOP) begin
            pc_q <= next_pc;
            ce_q <= 1'b1;
        end
    end

`ifdef IF_ADEL_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else if (stall[0] == NO_STOP) begin
            adel_q <= |next_pc[1:0];
        end
    end

    assign if_adel  = adel_q;
    assign fetch_ok = ce_q & ~adel_q;
`else
    assign fetch_ok = ce_q;
`endif

    assign to_id.ce        = fetch_ok;
    assign to_id.pc        = pc_q;
    assign if_to_id_bus    = to_id;
    assign inst_sram_en    = fetch_ok;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = '0;
    assign inst_sram_wdata = '0;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a cycle model plus literal spot checks.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
`ifdef IF_ADEL_CHECK_EN
    logic        if_adel;
`endif

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
`ifdef IF_ADEL_CHECK_EN
        .if_adel         (if_adel),
`endif
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    always #5 clk = ~clk;

    // Reference model: architectural fetch state advanced once per edge.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic        m_adel;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        logic [31:0] np;
        if (rst) begin
            m_pc = 32'hBFBF_FFFC;
            m_ce = 1'b0;
            m_pend = 1'b0;
            m_pend_addr = 32'h0;
            m_adel = 1'b0;
        end else if (!stall[0]) begin
            if (br_bus[32])  np = br_bus[31:0];
            else if (m_pend) np = m_pend_addr;
            else             np = m_pc + 32'd4;
            m_pc = np;
            m_ce = 1'b1;
            m_pend = 1'b0;
            m_adel = (np[1:0] != 2'b00);
        end else if (br_bus[32]) begin
            m_pend = 1'b1;
            m_pend_addr = br_bus[31:0];
        end
        m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_en;
        if (m_valid) begin
            exp_en = m_ce;
`ifdef IF_ADEL_CHECK_EN
            exp_en = m_ce & ~m_adel;
            chk("model_adel", {32'h0, if_adel}, {32'h0, m_adel});
`endif
            chk("model_addr", {1'b0, inst_sram_addr}, {1'b0, m_pc});
            chk("model_en", {32'h0, inst_sram_en}, {32'h0, exp_en});
            chk("model_bus", if_to_id_bus, {exp_en, m_pc});
            chk("model_wen", {29'h0, inst_sram_wen}, 33'h0);
            chk("model_wdata", {1'b0, inst_sram_wdata}, 33'h0);
        end
    end

    task automatic step(input logic s0, input logic be, input logic [31:0] ba);
        stall  = {5'b0, s0};
        br_bus = {be, ba};
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] addr, input logic en);
        chk({name, "_addr"}, {1'b0, inst_sram_addr}, {1'b0, addr});
        chk({name, "_en"}, {32'h0, inst_sram_en}, {32'h0, en});
        chk({name, "_ce"}, {32'h0, if_to_id_bus[32]}, {32'h0, en});
    endtask

    initial begin
        rst = 1'b1;
        stall = '0;
        br_bus = '0;
        step(0, 0, 0);
        step(0, 0, 0);
        lit("reset", 32'hBFBF_FFFC, 1'b0);
        rst = 1'b0;

        // Sequential fetch from reset vector
        step(0, 0, 0); lit("first", 32'hBFC0_0000, 1'b1);
        step(0, 0, 0); lit("seq1", 32'hBFC0_0004, 1'b1);
        step(0, 0, 0); lit("seq2", 32'hBFC0_0008, 1'b1);
        step(0, 0, 0);
        step(0, 0, 0); lit("seq4", 32'hBFC0_0010, 1'b1);

        // Redirect taken immediately
        step(0, 1, 32'hBFC0_0100); lit("br", 32'hBFC0_0100, 1'b1);
        step(0, 0, 0);             lit("br_seq", 32'hBFC0_0104, 1'b1);

        // Redirect raised mid-stall is replayed on release
        step(0, 1, 32'hBFC0_0020); lit("to20", 32'hBFC0_0020, 1'b1);
        step(1, 1, 32'hBFC0_0200); lit("stall1", 32'hBFC0_0020, 1'b1);
        step(1, 0, 0);             lit("stall2", 32'hBFC0_0020, 1'b1);
        step(1, 0, 0);             lit("stall3", 32'hBFC0_0020, 1'b1);
        step(0, 0, 0);             lit("release", 32'hBFC0_0200, 1'b1);
        step(0, 0, 0);             lit("pend_clr", 32'hBFC0_0204, 1'b1);

        // Live redirect beats pending one
        step(1, 1, 32'hBFC0_0300); lit("pend300", 32'hBFC0_0204, 1'b1);
        step(0, 1, 32'hBFC0_0400); lit("live_wins", 32'hBFC0_0400, 1'b1);
        step(0, 0, 0);             lit("live_seq", 32'hBFC0_0404, 1'b1);

        // Reset during stall with a pending redirect discards it
        step(1, 1, 32'hBFC0_0500);
        rst = 1'b1;
        step(1, 0, 0);             lit("rst_stall", 32'hBFBF_FFFC, 1'b0);
        rst = 1'b0;
        step(0, 0, 0);             lit("rst_first", 32'hBFC0_0000, 1'b1);
        step(0, 0, 0);             lit("rst_seq", 32'hBFC0_0004, 1'b1);

        // 32-bit wrap of the sequential PC
        step(0, 1, 32'hFFFF_FFFC); lit("pre_wrap", 32'hFFFF_FFFC, 1'b1);
        step(0, 0, 0);             lit("wrap", 32'h0000_0000, 1'b1);

        // Misaligned target
`ifdef IF_ADEL_CHECK_EN
        step(0, 1, 32'hBFC0_0102); lit("mis", 32'hBFC0_0102, 1'b0);
        chk("mis_adel", {32'h0, if_adel}, 33'h1);
        step(0, 0, 0);             lit("mis_seq", 32'hBFC0_0106, 1'b0);
`else
        step(0, 1, 32'hBFC0_0102); lit("mis", 32'hBFC0_0102, 1'b1);
        step(0, 0, 0);             lit("mis_seq", 32'hBFC0_0106, 1'b1);
`endif
        step(0, 1, 32'hBFC0_0200); lit("realign", 32'hBFC0_0200, 1'b1);
        step(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
